// File: rtl/dma_cmdq_pkg.sv
// Shared types and the round-robin search helper for the multi-channel DMA command queue.
package dma_cmdq_pkg;

    localparam int unsigned CMDQ_SRC_W   = 48;
    localparam int unsigned CMDQ_DST_W   = 48;
    localparam int unsigned CMDQ_LEN_W   = 40;
    localparam int unsigned CMDQ_MAX_CH  = 16;
    localparam int unsigned CMDQ_USEDW_W = 4;

    typedef struct packed {
        logic [CMDQ_SRC_W-1:0] src;
        logic [CMDQ_DST_W-1:0] dst;
        logic [CMDQ_LEN_W-1:0] len;
    } cmdq_cmd_t;

    typedef struct packed {
        logic                    empty;
        logic                    full;
        logic                    overflow;
        logic                    zlen;
        logic [CMDQ_USEDW_W-1:0] usedw;
    } cmdq_sts_t;

    // Returns {found, index}: first requester after ptr, wrapping within num_ch.
    function automatic logic [4:0] rr_next(input logic [CMDQ_MAX_CH-1:0] req,
                                           input logic [3:0]             ptr,
                                           input int unsigned            num_ch);
        logic       found;
        logic [3:0] idx;
        logic [3:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= CMDQ_MAX_CH; k++) begin
            cand = 4'((32'(ptr) + k) % num_ch);
            if (!found && (k <= num_ch) && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/dma_cmdq_fifo.sv
// Single-channel command FIFO with occupancy count and sticky drop flags.
// DMA_CMDQ_HIGHWATER_EN adds a per-queue occupancy high-water register.
module dma_cmdq_fifo #(
    parameter  int unsigned DEPTH   = 8,
    parameter  int unsigned W       = 136,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned USEDW_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic               push_zlen,
    input  logic [W-1:0]       push_data,
    input  logic               pop,
    input  logic               sclr,
    output logic [W-1:0]       head,
`ifdef DMA_CMDQ_HIGHWATER_EN
    output logic [USEDW_W-1:0] highwater,
`endif
    output logic [USEDW_W-1:0] usedw,
    output logic               empty,
    output logic               full,
    output logic               overflow,
    output logic               zlen
);

    logic [W-1:0]       mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;
    logic [USEDW_W-1:0] usedw_nxt;

    // A full queue still accepts a push when the same cycle pops it.
    always_comb begin
        do_pop    = pop && !empty && !sclr;
        do_push   = push && !push_zlen && !sclr && (!full || do_pop);
        usedw_nxt = usedw;
        if (sclr)
            usedw_nxt = '0;
        else if (do_push && !do_pop)
            usedw_nxt = usedw + USEDW_W'(1);
        else if (do_pop && !do_push)
            usedw_nxt = usedw - USEDW_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            usedw    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            zlen     <= 1'b0;
        end else begin
            usedw <= usedw_nxt;
            empty <= (usedw_nxt == '0);
            full  <= (usedw_nxt == USEDW_W'(DEPTH));
            if (sclr) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
                zlen     <= 1'b0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)
                    rd_ptr <= rd_ptr + AW'(1);
                if (push && push_zlen)
                    zlen <= 1'b1;
                if (push && !push_zlen && full && !do_pop)
                    overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

`ifdef DMA_CMDQ_HIGHWATER_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            highwater <= '0;
        else if (sclr)
            highwater <= '0;
        else if (usedw > highwater)
            highwater <= usedw;
    end
`endif

endmodule

// File: rtl/dma_cmdq_mc.sv
// NUM_CH independent command FIFOs behind a round-robin arbiter feeding one transfer controller.
// Optional DMA_CMDQ_HIGHWATER_EN exports per-channel occupancy high-water marks.
module dma_cmdq_mc
    import dma_cmdq_pkg::*;
#(
    parameter  int unsigned NUM_CH            = 4,
    parameter  int unsigned DEPTH             = 8,
    parameter  int unsigned SRC_ADDR_WIDTH    = 48,
    parameter  int unsigned DST_ADDR_WIDTH    = 48,
    parameter  int unsigned XFER_LENGTH_WIDTH = 40,
    localparam int unsigned CH_W              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned USEDW_W           = $clog2(DEPTH) + 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_CH-1:0]                 push,
    input  logic [NUM_CH*SRC_ADDR_WIDTH-1:0]  push_src,
    input  logic [NUM_CH*DST_ADDR_WIDTH-1:0]  push_dst,
    input  logic [NUM_CH*XFER_LENGTH_WIDTH-1:0] push_len,
    input  logic [NUM_CH-1:0]                 sclr,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CH_W-1:0]                   out_ch,
    output logic [SRC_ADDR_WIDTH-1:0]         out_src,
    output logic [DST_ADDR_WIDTH-1:0]         out_dst,
    output logic [XFER_LENGTH_WIDTH-1:0]      out_len,
    output logic [NUM_CH-1:0]                 sts_empty,
    output logic [NUM_CH-1:0]                 sts_full,
    output logic [NUM_CH-1:0]                 sts_overflow,
    output logic [NUM_CH-1:0]                 sts_zlen,
`ifdef DMA_CMDQ_HIGHWATER_EN
    output logic [NUM_CH*USEDW_W-1:0]         sts_highwater,
`endif
    output logic [NUM_CH*USEDW_W-1:0]         sts_usedw
);

    localparam int unsigned SW    = SRC_ADDR_WIDTH;
    localparam int unsigned DW    = DST_ADDR_WIDTH;
    localparam int unsigned LW    = XFER_LENGTH_WIDTH;
    localparam int unsigned CMD_W = SW + DW + LW;

    logic [CMD_W-1:0]  head [NUM_CH];
    logic [NUM_CH-1:0] pop;
    logic [4:0]        rr;
    logic              valid;
    logic [CH_W-1:0]   cur_ch;
    logic [CMD_W-1:0]  sel;
    logic              gnt_held;
    logic [CH_W-1:0]   gnt_ch;
    logic [CH_W-1:0]   ptr;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign pop[i] = valid && out_ready && (cur_ch == CH_W'(i)) && !sclr[i];

        dma_cmdq_fifo #(
            .DEPTH (DEPTH),
            .W     (CMD_W)
        ) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .push      (push[i]),
            .push_zlen (push_len[i*LW +: LW] == '0),
            .push_data ({push_src[i*SW +: SW], push_dst[i*DW +: DW], push_len[i*LW +: LW]}),
            .pop       (pop[i]),
            .sclr      (sclr[i]),
            .head      (head[i]),
`ifdef DMA_CMDQ_HIGHWATER_EN
            .highwater (sts_highwater[i*USEDW_W +: USEDW_W]),
`endif
            .usedw     (sts_usedw[i*USEDW_W +: USEDW_W]),
            .empty     (sts_empty[i]),
            .full      (sts_full[i]),
            .overflow  (sts_overflow[i]),
            .zlen      (sts_zlen[i])
        );
    end

    // Outputs are a combinational view of registered queue/grant state only; push never reaches them.
    always_comb begin
        rr = rr_next(CMDQ_MAX_CH'(~sts_empty), 4'(ptr), NUM_CH);
        if (gnt_held) begin
            valid  = 1'b1;
            cur_ch = gnt_ch;
        end else begin
            valid  = rr[4];
            cur_ch = CH_W'(rr[3:0]);
        end
        sel       = head[cur_ch];
        out_valid = valid;
        out_ch    = valid ? cur_ch : '0;
        out_src   = valid ? sel[CMD_W-1 -: SW] : '0;
        out_dst   = valid ? sel[LW+DW-1 -: DW] : '0;
        out_len   = valid ? sel[LW-1:0] : '0;
    end

    // A flush of the presented channel releases the grant and does not count as an accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_held <= 1'b0;
            gnt_ch   <= '0;
            ptr      <= CH_W'(NUM_CH - 1);
        end else if (valid && !sclr[cur_ch]) begin
            if (out_ready) begin
                gnt_held <= 1'b0;
                ptr      <= cur_ch;
            end else begin
                gnt_held <= 1'b1;
                gnt_ch   <= cur_ch;
            end
        end else begin
            gnt_held <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dma_cmdq_mc.sv
// Self-checking bench for dma_cmdq_mc: queue-based reference model, directed scenarios, random traffic.
module tb_dma_cmdq_mc;
    import dma_cmdq_pkg::*;

    localparam int NCH = 4;
    localparam int DEP = 8;
    localparam int SW  = 48;
    localparam int DW  = 48;
    localparam int LW  = 40;
    localparam int UW  = 4;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [NCH-1:0]      push = '0;
    logic [NCH*SW-1:0]   push_src = '0;
    logic [NCH*DW-1:0]   push_dst = '0;
    logic [NCH*LW-1:0]   push_len = '0;
    logic [NCH-1:0]      sclr = '0;
    logic                out_ready = 1'b0;
    logic                out_valid;
    logic [1:0]          out_ch;
    logic [SW-1:0]       out_src;
    logic [DW-1:0]       out_dst;
    logic [LW-1:0]       out_len;
    logic [NCH-1:0]      sts_empty, sts_full, sts_overflow, sts_zlen;
    logic [NCH*UW-1:0]   sts_usedw;
`ifdef DMA_CMDQ_HIGHWATER_EN
    logic [NCH*UW-1:0]   sts_highwater;
`endif

    always #5 clk = ~clk;

    dma_cmdq_mc #(
        .NUM_CH            (NCH),
        .DEPTH             (DEP),
        .SRC_ADDR_WIDTH    (SW),
        .DST_ADDR_WIDTH    (DW),
        .XFER_LENGTH_WIDTH (LW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .push         (push),
        .push_src     (push_src),
        .push_dst     (push_dst),
        .push_len     (push_len),
        .sclr         (sclr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ch       (out_ch),
        .out_src      (out_src),
        .out_dst      (out_dst),
        .out_len      (out_len),
        .sts_empty    (sts_empty),
        .sts_full     (sts_full),
        .sts_overflow (sts_overflow),
        .sts_zlen     (sts_zlen),
`ifdef DMA_CMDQ_HIGHWATER_EN
        .sts_highwater(sts_highwater),
`endif
        .sts_usedw    (sts_usedw)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: plain queues per channel plus sticky flags and arbitration state.
    cmdq_cmd_t mq [NCH][$];
    bit        m_ovf [NCH];
    bit        m_zl  [NCH];
    int        m_hw  [NCH];
    int        m_ptr;
    bit        m_held;
    int        m_gch;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NCH; i++) begin
            mq[i].delete();
            m_ovf[i] = 0;
            m_zl[i]  = 0;
            m_hw[i]  = 0;
        end
        m_ptr  = NCH - 1;
        m_held = 0;
        m_gch  = 0;
    endfunction

    function automatic void m_sel(output bit v, output int ch);
        v  = 0;
        ch = 0;
        if (m_held) begin
            v  = 1;
            ch = m_gch;
            return;
        end
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (m_ptr + k) % NCH;
            if (mq[c].size() != 0) begin
                v  = 1;
                ch = c;
                return;
            end
        end
    endfunction

    function automatic void m_step();
        bit        v, acc;
        int        ch;
        cmdq_cmd_t cmd;
        if (!reset_n) begin
            m_reset();
            return;
        end
        m_sel(v, ch);
        acc = v && out_ready && !sclr[ch];
        for (int i = 0; i < NCH; i++) begin
            int sz;
            bit popped;
            sz     = mq[i].size();
            popped = acc && (ch == i);
            if (sclr[i]) begin
                mq[i].delete();
                m_ovf[i] = 0;
                m_zl[i]  = 0;
                m_hw[i]  = 0;
            end else begin
                if (sz > m_hw[i]) m_hw[i] = sz;
                if (popped) void'(mq[i].pop_front());
                if (push[i]) begin
                    cmd.src = push_src[i*SW +: SW];
                    cmd.dst = push_dst[i*DW +: DW];
                    cmd.len = push_len[i*LW +: LW];
                    if (cmd.len == 0)
                        m_zl[i] = 1;
                    else if (sz == DEP && !popped)
                        m_ovf[i] = 1;
                    else
                        mq[i].push_back(cmd);
                end
            end
        end
        if (v && !sclr[ch]) begin
            if (out_ready) begin
                m_held = 0;
                m_ptr  = ch;
            end else begin
                m_held = 1;
                m_gch  = ch;
            end
        end else begin
            m_held = 0;
        end
    endfunction

    task automatic compare_all();
        bit          v;
        int          ch;
        logic [NCH-1:0]    e_empty, e_full, e_ovf, e_zl;
        logic [NCH*UW-1:0] e_used, e_hw;
        m_sel(v, ch);
        chk("out_valid", out_valid, v);
        if (v && mq[ch].size() != 0) begin
            chk("out_ch", out_ch, ch);
            chk("out_src", out_src, mq[ch][0].src);
            chk("out_dst", out_dst, mq[ch][0].dst);
            chk("out_len", out_len, mq[ch][0].len);
        end
        for (int i = 0; i < NCH; i++) begin
            e_empty[i] = (mq[i].size() == 0);
            e_full[i]  = (mq[i].size() == DEP);
            e_ovf[i]   = m_ovf[i];
            e_zl[i]    = m_zl[i];
            e_used[i*UW +: UW] = UW'(mq[i].size());
            e_hw[i*UW +: UW]   = UW'(m_hw[i]);
        end
        chk("sts_empty", sts_empty, e_empty);
        chk("sts_full", sts_full, e_full);
        chk("sts_overflow", sts_overflow, e_ovf);
        chk("sts_zlen", sts_zlen, e_zl);
        chk("sts_usedw", sts_usedw, e_used);
`ifdef DMA_CMDQ_HIGHWATER_EN
        chk("sts_highwater", sts_highwater, e_hw);
`else
        if (e_hw != e_hw) $display("unreachable");
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clr_in();
        push      = '0;
        sclr      = '0;
        push_len  = '0;
        out_ready = 1'b0;
    endtask

    task automatic set_push(input int i, input logic [SW-1:0] s, input logic [DW-1:0] d,
                            input logic [LW-1:0] l);
        push[i]              = 1'b1;
        push_src[i*SW +: SW] = s;
        push_dst[i*DW +: DW] = d;
        push_len[i*LW +: LW] = l;
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_empty", sts_empty, 4'hF);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_usedw", sts_usedw, 16'h0);
        chk("rst_out_src", out_src, 48'h0);
        reset_n = 1'b1;
        tick();

        // Single command latency and pop
        set_push(0, 48'h1000, 48'h2000, 40'd64);
        tick();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_ch", out_ch, 2'd0);
        chk("t1_src", out_src, 48'h1000);
        chk("t1_dst", out_dst, 48'h2000);
        chk("t1_len", out_len, 40'd64);
        clr_in();
        out_ready = 1'b1;
        tick();
        chk("t1_empty0", sts_empty[0], 1'b1);

        // Fill ch2, overflow, push+pop while full, then drain
        clr_in();
        for (int k = 0; k < 9; k++) begin
            set_push(2, 48'(32'hA000 + k), 48'(32'hB000 + k), 40'(k + 1));
            tick();
        end
        chk("t2_full2", sts_full[2], 1'b1);
        chk("t2_usedw2", sts_usedw[2*UW +: UW], 4'd8);
        chk("t2_ovf2", sts_overflow[2], 1'b1);
        set_push(2, 48'hC000, 48'hD000, 40'd77);
        out_ready = 1'b1;
        tick();
        chk("t2_usedw_pp", sts_usedw[2*UW +: UW], 4'd8);
        push = '0;
        repeat (9) tick();
        chk("t2_drained", sts_empty, 4'hF);

        // Round-robin order with all four channels loaded
        clr_in();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NCH; i++)
                set_push(i, 48'(16 * r + i), 48'(256 + 16 * r + i), 40'(1 + 16 * r + i));
            tick();
        end
        clr_in();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [1:0] e;
            e = 2'(k % 4);
            chk("t3_valid", out_valid, 1'b1);
            chk("t3_seq", out_ch, e);
            tick();
        end
        chk("t3_drained", sts_empty, 4'hF);

        // Grant held under backpressure
        clr_in();
        set_push(1, 48'h0000_1111_2222, 48'h3333_4444_5555, 40'h77);
        tick();
        for (int k = 0; k < 5; k++) begin
            clr_in();
            chk("t4_ch", out_ch, 2'd1);
            chk("t4_src", out_src, 48'h0000_1111_2222);
            chk("t4_len", out_len, 40'h77);
            set_push((k % 2 == 0) ? 0 : 3, 48'(k), 48'(k), 40'(k + 1));
            tick();
        end
        chk("t4_ch_last", out_ch, 2'd1);
        chk("t4_dst_last", out_dst, 48'h3333_4444_5555);
        clr_in();
        out_ready = 1'b1;
        tick();
        chk("t4_next", out_ch, 2'd3);
        for (int k = 0; k < 40 && sts_empty != 4'hF; k++) tick();
        chk("t4_drained", sts_empty, 4'hF);

        // Zero-length drop, then flush beating a push
        clr_in();
        set_push(1, 48'h5, 48'h6, 40'd0);
        tick();
        chk("t5_zlen1", sts_zlen[1], 1'b1);
        chk("t5_usedw1", sts_usedw[1*UW +: UW], 4'd0);
        clr_in();
        set_push(1, 48'h7, 48'h8, 40'd5);
        sclr[1] = 1'b1;
        tick();
        chk("t5_sclr_usedw", sts_usedw[1*UW +: UW], 4'd0);
        chk("t5_sclr_zlen", sts_zlen[1], 1'b0);
        chk("t5_sclr_empty", sts_empty[1], 1'b1);

        // Asynchronous reset in the middle of a burst
        clr_in();
        for (int i = 0; i < 3; i++) set_push(i, 48'(i + 9), 48'(i + 10), 40'(i + 11));
        tick();
        clr_in();
        out_ready = 1'b1;
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 1'b0);
        chk("t6_async_empty", sts_empty, 4'hF);
        m_reset();
        clr_in();
        tick();
        reset_n = 1'b1;
        tick();
        set_push(2, 48'h22, 48'h23, 40'd3);
        set_push(0, 48'h20, 48'h21, 40'd2);
        tick();
        chk("t6_first_ch", out_ch, 2'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            clr_in();
            for (int i = 0; i < NCH; i++) begin
                logic [LW-1:0] l;
                l = {8'($urandom), 32'($urandom)};
                if ($urandom_range(0, 15) == 0) l = '0;
                if ($urandom_range(0, 99) < 40)
                    set_push(i, {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)}, l);
                sclr[i] = ($urandom_range(0, 99) < 3);
            end
            out_ready = ($urandom_range(0, 99) < 60);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
